// File: rtl/pipeline_front_regs_pkg.sv
// Shared types and constants for the F/D/E pipeline registers.
package pkg_pipeline_regs;

   // Execute-stage control bundle produced by the decoder.
   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
   } ctrl_e_t;

   // All-zero control is a harmless bubble: no register or memory write, no branch/jump.
   localparam ctrl_e_t CTRL_E_BUBBLE = '0;

   // addi x0,x0,0 -- the canonical RISC-V no-op placed in decode on a flush.
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

// File: rtl/pipeline_front_regs_stage_reg.sv
// Generic pipeline register with enable and synchronous clear to the bubble value.
module pipeline_stage_reg #(
   parameter int           W   = 32,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear beats enable; with neither asserted the register holds its contents.
   // NOTE: the clear value is the same as the reset value, so a bubble is indistinguishable from the post-reset state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= RST;
      end else if (clr) begin
         q <= RST;
      end else if (en) begin
         // NOTE: non-blocking assignment keeps every stage sampling pre-edge values, so data advances exactly one stage per clock.
         q <= d;
      end
   end

endmodule

// File: rtl/pipeline_front_regs.sv
// PC (F), IF/ID (D) and ID/EX (E) pipeline registers driven by the hazard unit's
// stall/flush controls, with valid tracking and saturating stall/flush counters.
module pipeline_front_regs
   import pkg_pipeline_regs::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF,
   parameter int              CNT_W     = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            FlushE,
   input  logic [XLEN-1:0] PCNextF,
   input  logic [31:0]     InstrF,
   input  logic [XLEN-1:0] PCPlus4F,
   output logic [XLEN-1:0] PCF,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   input  ctrl_e_t         CtrlD,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   output ctrl_e_t         CtrlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            ValidE,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int DW = 32 + 2 * XLEN + 1;
   localparam int EW = $bits(ctrl_e_t) + 5 * XLEN + 3 * 5 + 1;

   // Decode bubble: no-op instruction, zero PCs, not valid.
   localparam logic [DW-1:0] D_BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

   logic [DW-1:0] dQ;
   logic [EW-1:0] eD;
   logic [EW-1:0] eQ;

   // Fetch PC: held while StallF, never flushed.
   pipeline_stage_reg #(.W(XLEN), .RST(RESET_PC)) uRegF (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (~StallF),
      .clr     (1'b0),
      .d       (PCNextF),
      .q       (PCF)
   );

   // IF/ID: flush wins over stall, a captured instruction is always valid.
   pipeline_stage_reg #(.W(DW), .RST(D_BUBBLE)) uRegD (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (~StallD),
      .clr     (FlushD),
      .d       ({InstrF, PCF, PCPlus4F, 1'b1}),
      .q       (dQ)
   );

   assign {InstrD, PCD, PCPlus4D, ValidD} = dQ;

   // ID/EX: never stalls; a flush zeroes control, operands and register indices so the
   // bubble cannot write state nor match any forwarding or load-use compare.
   assign eD = {CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD};

   pipeline_stage_reg #(.W(EW), .RST('0)) uRegE (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (1'b1),
      .clr     (FlushE),
      .d       (eD),
      .q       (eQ)
   );

   assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = eQ;

   // Saturating perf counters: count stall and execute-flush cycles, stick at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
         end
         if (FlushE && (FlushCount != {CNT_W{1'b1}})) begin
            FlushCount <= FlushCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed bench for pipeline_front_regs: reset, flow, load-use, branch flush,
// flush-over-stall, async reset mid-stall and counter saturation (CNT_W=4).
module tb_pipeline_front_regs;
   import pkg_pipeline_regs::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            StallF, StallD, FlushD, FlushE;
   logic [XLEN-1:0] PCNextF, PCPlus4F;
   logic [31:0]     InstrF;
   logic [XLEN-1:0] PCF, PCD, PCPlus4D;
   logic [31:0]     InstrD;
   logic            ValidD;
   ctrl_e_t         CtrlD, CtrlE;
   logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
   logic [4:0]      Rs1D, Rs2D, RdD;
   logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]      Rs1E, Rs2E, RdE;
   logic            ValidE;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int nVec = 0;
   int nErr = 0;

   ctrl_e_t ctrlA;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0010_0093;
   localparam logic [31:0] I1  = 32'h0020_0113;
   localparam logic [31:0] I2  = 32'h0030_2183;
   localparam logic [31:0] I3  = 32'h0031_8233;
   localparam logic [31:0] I4  = 32'h0000_0063;
   localparam logic [31:0] I5  = 32'h0050_0293;

   pipeline_front_regs #(.XLEN(XLEN), .RESET_PC('0), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .PCNextF    (PCNextF),
      .InstrF     (InstrF),
      .PCPlus4F   (PCPlus4F),
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .CtrlD      (CtrlD),
      .RD1D       (RD1D),
      .RD2D       (RD2D),
      .ImmExtD    (ImmExtD),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RdD        (RdD),
      .CtrlE      (CtrlE),
      .RD1E       (RD1E),
      .RD2E       (RD2E),
      .ImmExtE    (ImmExtE),
      .PCE        (PCE),
      .PCPlus4E   (PCPlus4E),
      .Rs1E       (Rs1E),
      .Rs2E       (Rs2E),
      .RdE        (RdE),
      .ValidE     (ValidE),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [XLEN-1:0] nxt, input logic [31:0] ins, input logic [XLEN-1:0] p4);
      PCNextF  = nxt;
      InstrF   = ins;
      PCPlus4F = p4;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      fetch(32'h40, 32'hDEAD_BEEF, 32'h44);
      CtrlD = ctrlA; RD1D = 32'h1111; RD2D = 32'h2222; ImmExtD = 32'h33;
      Rs1D = 5'd7; Rs2D = 5'd8; RdD = 5'd9;
      tick();
      tick();
      nVec++; if (PCF !== 32'h0) begin nErr++; $display("FAIL reset_PCF got %h exp %h", PCF, 32'h0); end
      nVec++; if (InstrD !== NOP) begin nErr++; $display("FAIL reset_InstrD got %h exp %h", InstrD, NOP); end
      nVec++; if ({PCD, PCPlus4D, ValidD} !== {64'h0, 1'b0}) begin nErr++;
         $display("FAIL reset_D got %h %h %b exp 0 0 0", PCD, PCPlus4D, ValidD); end
      nVec++; if ({ValidE, CtrlE, RdE, Rs1E, RD1E, PCE} !== '0) begin nErr++;
         $display("FAIL reset_E got valid=%b ctrl=%h rd=%0d rs1=%0d rd1=%h pc=%h exp all 0",
                  ValidE, CtrlE, RdE, Rs1E, RD1E, PCE); end
      nVec++; if ({StallCount, FlushCount} !== 8'h00) begin nErr++;
         $display("FAIL reset_counters got %0d %0d exp 0 0", StallCount, FlushCount); end
      reset_n = 1'b1;
   endtask

   task automatic test_flow();
      RD1D = 32'hAAAA; RD2D = 32'h5555; ImmExtD = 32'h10;
      Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; CtrlD = ctrlA;
      fetch(32'd4, I0, 32'd4);
      tick();
      nVec++; if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'd4, I0, 32'd0, 32'd4, 1'b1}) begin nErr++;
         $display("FAIL flow1_D got pcf=%h instr=%h pcd=%h p4d=%h v=%b exp 4 %h 0 4 1", PCF, InstrD, PCD, PCPlus4D, ValidD, I0); end
      nVec++; if (ValidE !== 1'b0) begin nErr++; $display("FAIL flow1_ValidE got %b exp 0", ValidE); end
      fetch(32'd8, I1, 32'd8);
      tick();
      nVec++; if ({PCF, InstrD, PCD} !== {32'd8, I1, 32'd4}) begin nErr++;
         $display("FAIL flow2_D got pcf=%h instr=%h pcd=%h exp 8 %h 4", PCF, InstrD, PCD, I1); end
      nVec++; if ({ValidE, PCE, PCPlus4E} !== {1'b1, 32'd0, 32'd4}) begin nErr++;
         $display("FAIL flow2_E got v=%b pce=%h p4e=%h exp 1 0 4", ValidE, PCE, PCPlus4E); end
      nVec++; if ({CtrlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE} !==
                  {ctrlA, 32'hAAAA, 32'h5555, 32'h10, 5'd1, 5'd2, 5'd3}) begin nErr++;
         $display("FAIL flow2_Eops got ctrl=%h rd1=%h rd2=%h imm=%h rs=%0d,%0d rd=%0d exp %h aaaa 5555 10 1,2 3",
                  CtrlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, ctrlA); end
      fetch(32'd12, I2, 32'd12);
      tick();
      nVec++; if ({PCF, InstrD, PCD, PCE} !== {32'd12, I2, 32'd8, 32'd4}) begin nErr++;
         $display("FAIL flow3 got pcf=%h instr=%h pcd=%h pce=%h exp c %h 8 4", PCF, InstrD, PCD, PCE, I2); end
   endtask

   task automatic test_load_use();
      RdD = 5'd5;
      fetch(32'd16, I3, 32'd16);
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
      tick();
      nVec++; if ({PCF, InstrD, PCD, ValidD} !== {32'd12, I2, 32'd8, 1'b1}) begin nErr++;
         $display("FAIL lu_hold got pcf=%h instr=%h pcd=%h v=%b exp c %h 8 1", PCF, InstrD, PCD, ValidD, I2); end
      nVec++; if ({ValidE, CtrlE.RegWrite, CtrlE.MemWrite, RdE, Rs1E, Rs2E, RD1E} !== '0) begin nErr++;
         $display("FAIL lu_bubble got v=%b rw=%b mw=%b rd=%0d rs=%0d,%0d rd1=%h exp all 0",
                  ValidE, CtrlE.RegWrite, CtrlE.MemWrite, RdE, Rs1E, Rs2E, RD1E); end
      nVec++; if ({StallCount, FlushCount} !== {4'd1, 4'd1}) begin nErr++;
         $display("FAIL lu_counters got %0d %0d exp 1 1", StallCount, FlushCount); end
      StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
      tick();
      nVec++; if ({PCF, InstrD, PCD, PCE, RdE, ValidE} !== {32'd16, I3, 32'd12, 32'd8, 5'd5, 1'b1}) begin nErr++;
         $display("FAIL lu_resume got pcf=%h instr=%h pcd=%h pce=%h rd=%0d v=%b exp 10 %h c 8 5 1",
                  PCF, InstrD, PCD, PCE, RdE, ValidE, I3); end
   endtask

   task automatic test_branch();
      fetch(32'h100, I4, 32'd20);
      FlushD = 1'b1; FlushE = 1'b1;
      tick();
      nVec++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 64'h0, 1'b0}) begin nErr++;
         $display("FAIL br_D got instr=%h pcd=%h p4d=%h v=%b exp %h 0 0 0", InstrD, PCD, PCPlus4D, ValidD, NOP); end
      nVec++; if ({ValidE, CtrlE} !== '0) begin nErr++;
         $display("FAIL br_E got v=%b ctrl=%h exp 0 0", ValidE, CtrlE); end
      nVec++; if (PCF !== 32'h100) begin nErr++; $display("FAIL br_PCF got %h exp 100", PCF); end
      nVec++; if ({StallCount, FlushCount} !== {4'd1, 4'd2}) begin nErr++;
         $display("FAIL br_counters got %0d %0d exp 1 2", StallCount, FlushCount); end
      FlushD = 1'b0; FlushE = 1'b0;
      fetch(32'h104, I5, 32'h104);
      tick();
      nVec++; if ({PCF, InstrD, PCD, ValidD, ValidE} !== {32'h104, I5, 32'h100, 1'b1, 1'b0}) begin nErr++;
         $display("FAIL br_after got pcf=%h instr=%h pcd=%h vd=%b ve=%b exp 104 %h 100 1 0",
                  PCF, InstrD, PCD, ValidD, ValidE, I5); end
   endtask

   task automatic test_flush_over_stall();
      fetch(32'h108, I0, 32'h108);
      StallD = 1'b1; FlushD = 1'b1;
      tick();
      nVec++; if ({InstrD, PCD, ValidD} !== {NOP, 32'h0, 1'b0}) begin nErr++;
         $display("FAIL fos_D got instr=%h pcd=%h v=%b exp %h 0 0", InstrD, PCD, ValidD, NOP); end
      nVec++; if (PCF !== 32'h108) begin nErr++; $display("FAIL fos_PCF got %h exp 108", PCF); end
      StallD = 1'b0; FlushD = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
      tick();
      tick();
      nVec++; if ({StallCount, FlushCount} !== {4'd3, 4'd4}) begin nErr++;
         $display("FAIL rms_pre got %0d %0d exp 3 4", StallCount, FlushCount); end
      #2 reset_n = 1'b0;
      #1;
      nVec++; if ({PCF, InstrD, ValidD, ValidE, StallCount, FlushCount} !== {32'h0, NOP, 1'b0, 1'b0, 8'h00}) begin nErr++;
         $display("FAIL rms_async got pcf=%h instr=%h vd=%b ve=%b sc=%0d fc=%0d exp 0 %h 0 0 0 0",
                  PCF, InstrD, ValidD, ValidE, StallCount, FlushCount, NOP); end
      tick();
      StallD = 1'b0; FlushE = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_saturation();
      StallF = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      nVec++; if (StallCount !== 4'd14) begin nErr++; $display("FAIL sat14 got %0d exp 14", StallCount); end
      tick();
      nVec++; if (StallCount !== 4'd15) begin nErr++; $display("FAIL sat15 got %0d exp 15", StallCount); end
      for (int i = 0; i < 5; i++) tick();
      nVec++; if (StallCount !== 4'd15) begin nErr++; $display("FAIL sat20 got %0d exp 15", StallCount); end
      nVec++; if ({PCF, FlushCount} !== {32'h0, 4'd0}) begin nErr++;
         $display("FAIL sat_other got pcf=%h fc=%0d exp 0 0", PCF, FlushCount); end
      StallF = 1'b0;
   endtask

   initial begin
      ctrlA = '0;
      ctrlA.RegWrite   = 1'b1;
      ctrlA.ResultSrc  = 2'b01;
      ctrlA.ALUControl = 3'b010;
      ctrlA.ALUSrc     = 1'b1;
      test_reset();
      test_flow();
      test_load_use();
      test_branch();
      test_flush_over_stall();
      test_reset_mid_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
